// File: rtl/clk_sched_pkg.sv
// Shared encodings and phase-decode constants for the 8f clock scheduler.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sched_state_e;

    localparam int             PH_W     = 3;
    localparam logic [PH_W-1:0] PH_LAST  = 3'd7;
    localparam logic [1:0]      PH2_MASK = 2'd3;

endpackage

// File: rtl/clk_sched_ctrl_if.sv
// Request/status bundle between the control logic and the clock scheduler.
interface clk_sched_ctrl_if;
    import clk_sched_pkg::*;

    logic              en_req;
    logic              stop_req;
    logic [PH_W-1:0]   ph;
    logic              ce_4f;
    logic              ce_2f;
    logic              ce_f;
    logic [1:0]        lane_sel;
    logic              running;
    logic              ack;
    sched_state_e      state;

    modport master (
        output en_req, stop_req,
        input  ph, ce_4f, ce_2f, ce_f, lane_sel, running, ack, state
    );

    modport slave (
        input  en_req, stop_req,
        output ph, ce_4f, ce_2f, ce_f, lane_sel, running, ack, state
    );

endinterface

// File: rtl/clk_phase_cnt.sv
// Free-running 3-bit phase counter with synchronous clear and count enable.
module clk_phase_cnt
    import clk_sched_pkg::*;
(
    input  logic            clk8f,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    output logic [PH_W-1:0] ph
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk8f or posedge reset) begin
        if (reset)
            ph <= '0;
        else if (clr)
            ph <= '0;
        else if (en)
            ph <= ph + PH_W'(1);
    end

endmodule

// File: rtl/clk_sched_ctrl.sv
// Start/stop FSM and strobe scheduler for the f/2f/4f domains, clocked at 8f.
module clk_sched_ctrl
    import clk_sched_pkg::*;
#(
    parameter int SYNC_CYCLES = 16,
    parameter int SYNC_W      = 5
)(
    input  logic             clk8f,
    input  logic             reset,
    clk_sched_ctrl_if.slave  bus
);

    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);

    sched_state_e      state_q, state_d;
    logic [SYNC_W-1:0] sync_cnt;
    logic [PH_W-1:0]   ph;
    logic              ph_clr, ph_en;
    logic              ack_d, ack_q;
    logic              running;

    clk_phase_cnt u_phase_cnt (
        .clk8f (clk8f),
        .reset (reset),
        .clr   (ph_clr),
        .en    (ph_en),
        .ph    (ph)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ph_clr  = 1'b0;
        ph_en   = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                ph_clr = 1'b1;
                if (bus.en_req && !bus.stop_req)
                    state_d = SYNC;
            end
            SYNC: begin
                if (!bus.en_req) begin
                    state_d = IDLE;
                    ph_clr  = 1'b1;
                end else begin
                    // SYNC_CYCLES is a multiple of 8, so ph wraps to 0 exactly as RUN begins.
                    ph_en = 1'b1;
                    if (sync_cnt == SYNC_LAST) begin
                        state_d = RUN;
                        ack_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                ph_en = 1'b1;
                if (bus.stop_req)
                    state_d = DRAIN;
            end
            DRAIN: begin
                ph_en = 1'b1;
                if (ph == PH_LAST) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk8f or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sync_cnt <= '0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            sync_cnt <= (state_q == SYNC) ? sync_cnt + SYNC_W'(1) : '0;
        end
    end

    // Strobes decode only registered state and phase, keeping outputs glitch-free.
    assign running      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.ph       = ph;
    assign bus.running  = running;
    assign bus.ce_4f    = running && ph[0];
    assign bus.ce_2f    = running && ((ph[1:0] & PH2_MASK) == PH2_MASK);
    assign bus.ce_f     = running && (ph == PH_LAST);
    assign bus.lane_sel = running ? ph[2:1] : 2'b00;
    assign bus.ack      = ack_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_clk_sched_ctrl.sv
// Directed, table-driven bench for the 8f clock scheduler.
module tb_clk_sched_ctrl;
    import clk_sched_pkg::*;

    logic clk8f = 1'b0;
    logic reset;

    clk_sched_ctrl_if bus ();

    clk_sched_ctrl #(.SYNC_CYCLES(16), .SYNC_W(5)) dut (
        .clk8f (clk8f),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk8f = ~clk8f;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       stop;
        logic [1:0] st;
        logic [2:0] ph;
        logic       c4;
        logic       c2;
        logic       cf;
        logic [1:0] lane;
        logic       run;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic stop, input logic [1:0] st,
                                input logic [2:0] ph, input logic c4, input logic c2,
                                input logic cf, input logic [1:0] lane, input logic run,
                                input logic ack);
        vec_t v;
        v.en = en; v.stop = stop; v.st = st; v.ph = ph;
        v.c4 = c4; v.c2 = c2; v.cf = cf; v.lane = lane; v.run = run; v.ack = ack;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [2:0] ph,
                              input logic c4, input logic c2, input logic cf,
                              input logic [1:0] lane, input logic run, input logic ack);
        check({tag, ".state"},    32'(bus.state),    32'(st));
        check({tag, ".ph"},       32'(bus.ph),       32'(ph));
        check({tag, ".ce_4f"},    32'(bus.ce_4f),    32'(c4));
        check({tag, ".ce_2f"},    32'(bus.ce_2f),    32'(c2));
        check({tag, ".ce_f"},     32'(bus.ce_f),     32'(cf));
        check({tag, ".lane_sel"}, 32'(bus.lane_sel), 32'(lane));
        check({tag, ".running"},  32'(bus.running),  32'(run));
        check({tag, ".ack"},      32'(bus.ack),      32'(ack));
    endtask

    task automatic step();
        @(posedge clk8f);
        #1;
    endtask

    initial begin
        // Full SYNC, first two RUN frames, stop pulse at ph=2 and the drain to IDLE.
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(1, 0, SYNC, 3'(j % 8), 0, 0, 0, 2'd0, 0, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd0, 0, 0, 0, 2'd0, 1, 1));
        vecs.push_back(mk(1, 0, RUN,   3'd1, 1, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd2, 0, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd3, 1, 1, 0, 2'd1, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd4, 0, 0, 0, 2'd2, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd5, 1, 0, 0, 2'd2, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd6, 0, 0, 0, 2'd3, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd7, 1, 1, 1, 2'd3, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd0, 0, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd1, 1, 0, 0, 2'd0, 1, 0));
        vecs.push_back(mk(1, 0, RUN,   3'd2, 0, 0, 0, 2'd1, 1, 0));
        vecs.push_back(mk(1, 1, DRAIN, 3'd3, 1, 1, 0, 2'd1, 1, 0));
        vecs.push_back(mk(1, 0, DRAIN, 3'd4, 0, 0, 0, 2'd2, 1, 0));
        vecs.push_back(mk(1, 0, DRAIN, 3'd5, 1, 0, 0, 2'd2, 1, 0));
        vecs.push_back(mk(1, 0, DRAIN, 3'd6, 0, 0, 0, 2'd3, 1, 0));
        vecs.push_back(mk(1, 0, DRAIN, 3'd7, 1, 1, 1, 2'd3, 1, 0));
        vecs.push_back(mk(0, 0, IDLE,  3'd0, 0, 0, 0, 2'd0, 0, 1));
        vecs.push_back(mk(0, 0, IDLE,  3'd0, 0, 0, 0, 2'd0, 0, 0));

        reset        = 1'b1;
        bus.en_req   = 1'b0;
        bus.stop_req = 1'b0;
        #2;
        expect_out("reset", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        repeat (2) @(posedge clk8f);
        #3;
        reset = 1'b0;
        step();
        expect_out("idle", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);

        // en_req with stop_req in IDLE: stop wins
        bus.en_req   = 1'b1;
        bus.stop_req = 1'b1;
        repeat (2) begin
            step();
            expect_out("idle_both", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        end

        foreach (vecs[i]) begin
            bus.en_req   = vecs[i].en;
            bus.stop_req = vecs[i].stop;
            step();
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].ph, vecs[i].c4,
                       vecs[i].c2, vecs[i].cf, vecs[i].lane, vecs[i].run, vecs[i].ack);
        end

        // SYNC abort after 5 cycles, then a full restart
        bus.en_req = 1'b1;
        step();
        expect_out("abort_s1", SYNC, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        repeat (4) step();
        expect_out("abort_s5", SYNC, 3'd4, 0, 0, 0, 2'd0, 0, 0);
        bus.en_req = 1'b0;
        step();
        expect_out("abort_idle", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        step();
        expect_out("abort_idle2", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        bus.en_req = 1'b1;
        step();
        expect_out("resync_0", SYNC, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        for (int j = 1; j < 16; j++) begin
            step();
            expect_out($sformatf("resync_%0d", j), SYNC, 3'(j % 8), 0, 0, 0, 2'd0, 0, 0);
        end
        step();
        expect_out("rerun", RUN, 3'd0, 0, 0, 0, 2'd0, 1, 1);

        // stop_req raised exactly at ph=7 gives a full 8-cycle DRAIN frame
        repeat (7) step();
        expect_out("run_ph7", RUN, 3'd7, 1, 1, 1, 2'd3, 1, 0);
        bus.stop_req = 1'b1;
        step();
        expect_out("drain_ph0", DRAIN, 3'd0, 0, 0, 0, 2'd0, 1, 0);
        bus.stop_req = 1'b0;
        for (int j = 1; j < 7; j++) begin
            step();
            check($sformatf("drain_st%0d", j), 32'(bus.state), 32'(DRAIN));
            check($sformatf("drain_ph%0d", j), 32'(bus.ph), 32'(j));
        end
        bus.en_req = 1'b0;
        step();
        expect_out("drain_ph7", DRAIN, 3'd7, 1, 1, 1, 2'd3, 1, 0);
        step();
        expect_out("drain_done", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 1);

        // asynchronous reset mid-RUN at ph=5
        bus.en_req = 1'b1;
        step();
        repeat (16) step();
        expect_out("run2_ph0", RUN, 3'd0, 0, 0, 0, 2'd0, 1, 1);
        repeat (5) step();
        expect_out("run2_ph5", RUN, 3'd5, 1, 0, 0, 2'd2, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        expect_out("async_rst", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        bus.en_req = 1'b0;
        #3;
        reset = 1'b0;
        repeat (3) begin
            step();
            expect_out("post_rst", IDLE, 3'd0, 0, 0, 0, 2'd0, 0, 0);
        end
        bus.en_req = 1'b1;
        step();
        expect_out("post_rst_sync", SYNC, 3'd0, 0, 0, 0, 2'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
